// File: rtl/width_adapter_pkg.sv
// Shared types and helpers for the width adapter: datapath mode selector and
// the lane-mask function used to build out_keep.
package width_adapter_pkg;

    typedef enum logic [1:0] {
        MODE_PACK     = 2'd0,
        MODE_ZERO_PAD = 2'd1,
        MODE_SIGN_EXT = 2'd2
    } mode_e;

    localparam int MAX_RATIO = 32;

    // Mask with bits 0..n set; callers truncate to their lane count.
    function automatic logic [MAX_RATIO-1:0] lane_mask(input int n);
        logic [MAX_RATIO-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_RATIO; i++) m[i] = (i <= n);
        return m;
    endfunction

endpackage

// File: rtl/width_adapter_if.sv
// Narrow-in / wide-out streaming bus of the width adapter.
interface width_adapter_if #(
    parameter int IN_W  = 8,
    parameter int RATIO = 2
);
    localparam int OUT_W = IN_W * RATIO;

    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic [RATIO-1:0] out_keep;
    logic             out_last;

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_keep, out_last
    );

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_keep, out_last
    );
endinterface

// File: rtl/width_adapter_oreg.sv
// Single valid/ready register stage; payload only changes on a load, so it
// holds steady while the sink stalls.
module width_adapter_oreg #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);
    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_valid && in_ready) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: rtl/width_adapter.sv
// Widens IN_W-bit beats to IN_W*RATIO-bit words, either packing successive
// beats little-endian or padding/sign-extending each beat on its own.
module width_adapter
    import width_adapter_pkg::*;
#(
    parameter int    IN_W  = 8,
    parameter int    RATIO = 2,
    parameter mode_e MODE  = MODE_PACK
) (
    input logic            clk,
    input logic            rst,
    width_adapter_if.slave bus
);
    localparam int OUT_W = IN_W * RATIO;

    typedef struct packed {
        logic [OUT_W-1:0] data;
        logic [RATIO-1:0] keep;
        logic             last;
    } word_t;

    word_t w_word, o_word;
    logic  w_final;
    logic  in_ready;

    assign bus.in_ready = in_ready;

    if (IN_W < 1 || RATIO < 1 || RATIO > MAX_RATIO) begin : g_bad_param
        $error("width_adapter: illegal IN_W/RATIO");
    end

    if (MODE == MODE_PACK && RATIO > 1) begin : g_pack
        localparam int             CW        = $clog2(RATIO);
        localparam logic [CW-1:0]  LAST_LANE = CW'(RATIO - 1);

        logic [CW-1:0]                cnt;
        logic [RATIO-2:0][IN_W-1:0]   acc;
        logic                         beat_fire;

        assign beat_fire = bus.in_valid && in_ready;
        assign w_final   = (cnt == LAST_LANE) || bus.in_last;

        // Lanes past cnt are already zero in acc, so unfilled lanes come out zero.
        always_comb begin
            w_word.data = '0;
            for (int i = 0; i < RATIO - 1; i++)
                w_word.data[i*IN_W +: IN_W] = (cnt == CW'(i)) ? bus.in_data : acc[i];
            w_word.data[(RATIO-1)*IN_W +: IN_W] = (cnt == LAST_LANE) ? bus.in_data : '0;
            w_word.keep = RATIO'(lane_mask(int'(cnt)));
            w_word.last = bus.in_last;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                cnt <= '0;
                acc <= '0;
            end else if (beat_fire) begin
                if (w_final) begin
                    cnt <= '0;
                    acc <= '0;
                end else begin
                    for (int i = 0; i < RATIO - 1; i++)
                        if (cnt == CW'(i)) acc[i] <= bus.in_data;
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end else if (MODE == MODE_PACK || MODE == MODE_ZERO_PAD || MODE == MODE_SIGN_EXT) begin : g_pad
        // RATIO==1 packing degenerates to this pass-through as well.
        assign w_final = 1'b1;

        always_comb begin
            w_word.data            = '0;
            w_word.data[IN_W-1:0]  = bus.in_data;
            if (MODE == MODE_SIGN_EXT)
                for (int i = IN_W; i < OUT_W; i++) w_word.data[i] = bus.in_data[IN_W-1];
            w_word.keep = '1;
            w_word.last = bus.in_last;
        end
    end else begin : g_bad_mode
        $error("width_adapter: unknown MODE");
    end

    width_adapter_oreg #(.WIDTH($bits(word_t))) u_oreg (
        .clk      (clk),
        .rst      (rst),
        .in_valid (bus.in_valid && w_final),
        .in_ready (in_ready),
        .in_data  (w_word),
        .out_valid(bus.out_valid),
        .out_ready(bus.out_ready),
        .out_data (o_word)
    );

    assign bus.out_data = o_word.data;
    assign bus.out_keep = o_word.keep;
    assign bus.out_last = o_word.last;
endmodule
